// File: rtl/div_restoring_datapath.sv
// Unsigned restoring divider: latches operands on start, one shift/subtract per enabled
// counter cycle, ends on the counter's overflow. Optional divide-by-zero bypass: DIV_ZERO_DET_EN.
module div_restoring_datapath #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             iter_ovf,
  output logic             iter_enb,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  state_t state;

  // Partial remainder is always < divisor, so WIDTH bits suffice between steps;
  // the extra bit only exists in the shifted/trial values.
  logic [WIDTH-1:0] rem_r, quo_r, dsr_r;
  logic [WIDTH:0]   shl_rem, trial;

  assign shl_rem  = {rem_r, quo_r[WIDTH-1]};
  assign trial    = shl_rem - {1'b0, dsr_r};
  assign iter_enb = (state == ITER) && !iter_ovf;
  assign ready    = (state == IDLE);
  assign busy     = (state != IDLE);

`ifdef DIV_ZERO_DET_EN
  logic zero_pend;
`else
  assign div_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rem_r     <= '0;
      quo_r     <= '0;
      dsr_r     <= '0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
`ifdef DIV_ZERO_DET_EN
      div_zero  <= 1'b0;
      zero_pend <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          rem_r <= '0;
          quo_r <= dividend;
          dsr_r <= divisor;
          state <= ITER;
`ifdef DIV_ZERO_DET_EN
          div_zero <= 1'b0;
          if (divisor == '0) begin
            state     <= DONE;
            zero_pend <= 1'b1;
          end
`endif
        end
        ITER: begin
          if (iter_ovf) begin
            quotient  <= quo_r;
            remainder <= rem_r;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            // Negative trial means restore: keep the shifted remainder, quotient bit 0.
            rem_r <= trial[WIDTH] ? shl_rem[WIDTH-1:0] : trial[WIDTH-1:0];
            quo_r <= {quo_r[WIDTH-2:0], ~trial[WIDTH]};
          end
        end
        DONE: begin
          state <= IDLE;
`ifdef DIV_ZERO_DET_EN
          if (zero_pend) begin
            quotient  <= '1;
            remainder <= quo_r;
            div_zero  <= 1'b1;
            done      <= 1'b1;
            zero_pend <= 1'b0;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_restoring_datapath.sv
// Randomized bench for div_restoring_datapath with a cycle-exact model of the 16-step counter.
module tb_div_restoring_datapath;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic iter_ovf, iter_enb, ready, busy, done, div_zero;
  logic [W-1:0] quotient, remainder;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_restoring_datapath #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .iter_ovf(iter_ovf), .iter_enb(iter_enb), .ready(ready), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  // Iteration counter: reloads to 15, decrements when enabled, registered overflow after the 16th step.
  logic [3:0] cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= 4'd15;
      iter_ovf <= 1'b0;
    end else if (iter_enb) begin
      iter_ovf <= (cnt == 4'd0);
      cnt      <= (cnt == 4'd0) ? 4'd15 : cnt - 4'd1;
    end else begin
      iter_ovf <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int t = 0;
    @(negedge clk);
    while (!ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!ready) chk({tag, "_ready_to"}, 0, 1);
  endtask

  // One division; optionally fires stray start pulses with other operands while busy.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit noise, input string tag);
    logic [W-1:0] eq, er;
    int elat, eenb, lat, enb;
    bit edz, got;
    bit det = 1'b0;
`ifdef DIV_ZERO_DET_EN
    det = 1'b1;
`endif
    edz  = det && (b == 0);
    eq   = (b == 0) ? {W{1'b1}} : a / b;
    er   = (b == 0) ? a : a % b;
    elat = edz ? 1 : 17;
    eenb = edz ? 0 : 16;

    wait_ready(tag);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; enb = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else begin
        if (iter_enb) enb++;
        dividend = W'($urandom); divisor = W'($urandom);
        start = noise;
        @(posedge clk);
        lat++;
        #1 start = 1'b0;
      end
    end
    if (!got) chk({tag, "_done_to"}, 0, 1);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_enb"}, enb, eenb);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dz"}, div_zero, edz);
    @(negedge clk);
    chk({tag, "_pulse"}, done, 0);
    chk({tag, "_hold_q"}, quotient, eq);
    chk({tag, "_rdy"}, ready, 1);
  endtask

  initial begin
    #12;
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_rdy", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_enb", iter_enb, 0);
    chk("rst_done", done, 0);
    @(negedge clk) rst = 1'b1;

    do_div(16'd100, 16'd7, 1'b0, "d100_7");
    do_div(16'hFFFF, 16'd1, 1'b0, "ffff_1");
    do_div(16'd5, 16'd9, 1'b0, "d5_9");
    do_div(16'h8000, 16'h8000, 1'b0, "h8000");
    do_div(16'd1000, 16'd10, 1'b0, "b2b_a");
    do_div(16'd65535, 16'd256, 1'b0, "b2b_b");
    do_div(16'd4321, 16'd17, 1'b1, "noise");
    do_div(16'd1234, 16'd0, 1'b0, "zero");

    // Abort mid-operation after 8 steps.
    wait_ready("abort");
    start = 1'b1; dividend = 16'd1000; divisor = 16'd10;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_rdy", ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_enb", iter_enb, 0);
    chk("abort_dz", div_zero, 0);
    @(negedge clk) rst = 1'b1;
    do_div(16'd1000, 16'd10, 1'b0, "post_rst");

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      case ($urandom_range(0, 3))
        0: b = W'($urandom_range(1, 15));
        1: b = (i % 6 == 0) ? '0 : W'($urandom_range(1, 255));
        default: b = W'($urandom);
      endcase
      do_div(a, b, 1'($urandom_range(0, 1)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
